// File: rtl/halut_pkg.sv
// Shared constants and types for the HALUT encoder/decoder pair.
package halut_pkg;

  typedef enum logic {
    FP32 = 1'b0,
    INT  = 1'b1
  } accumulation_enum_t;

  localparam int unsigned K             = 16;
  localparam int unsigned C             = 32;
  localparam int unsigned DataTypeWidth = 16;

  localparam accumulation_enum_t AccumulationOption = INT;

  // One tree level per pipeline stage.
  localparam int unsigned EncoderLatency = $clog2(K);

endpackage

// File: rtl/halut_encoder_level.sv
// One decision-tree level: owns the thresholds for its nodes across all
// codebooks, compares the current feature and extends the prefix.
module halut_encoder_level
  import halut_pkg::*;
#(
  parameter int unsigned        Level              = 0,
  parameter int unsigned        K                  = halut_pkg::K,
  parameter int unsigned        C                  = halut_pkg::C,
  parameter int unsigned        DataTypeWidth      = halut_pkg::DataTypeWidth,
  parameter accumulation_enum_t AccumulationOption = halut_pkg::AccumulationOption,
  localparam int unsigned       TreeDepth          = $clog2(K),
  localparam int unsigned       CAddrWidth         = $clog2(C),
  localparam int unsigned       TotalAddrWidth     = $clog2(C * K)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [TotalAddrWidth-1:0]          waddr_i,
  input  logic [DataTypeWidth-1:0]           wdata_i,
  input  logic                               we_i,
  input  logic                               valid_i,
  input  logic [CAddrWidth-1:0]              c_i,
  input  logic [TreeDepth-1:0]               prefix_i,
  input  logic [TreeDepth*DataTypeWidth-1:0] a_i,
  output logic                               valid_o,
  output logic [CAddrWidth-1:0]              c_o,
  output logic [TreeDepth-1:0]               prefix_o,
  output logic [TreeDepth*DataTypeWidth-1:0] a_o
);

  // Nodes of this level are heap indices Base .. Base+Nodes-1.
  localparam int unsigned Nodes    = 1 << Level;
  localparam int unsigned Base     = Nodes - 1;
  localparam int unsigned IdxWidth = (Level == 0) ? 1 : Level;

  logic [DataTypeWidth-1:0] thr_q [C][Nodes];

  logic [CAddrWidth-1:0]             wc;
  logic [TreeDepth-1:0]              wnode;
  logic                              whit;
  logic [IdxWidth-1:0]               widx;
  logic [IdxWidth-1:0]               ridx;
  logic [DataTypeWidth-1:0]          thr;
  logic [DataTypeWidth-1:0]          feat;
  logic                              bit_gt;

  logic                              valid_q;
  logic [CAddrWidth-1:0]             c_q;
  logic [TreeDepth-1:0]              prefix_q;
  logic [TreeDepth*DataTypeWidth-1:0] a_q;

  // Sign-magnitude to ordered unsigned key; both zeros share one key,
  // NaN patterns are ordered like any other magnitude.
  function automatic logic [DataTypeWidth-1:0] fp_key(input logic [DataTypeWidth-1:0] x);
    logic [DataTypeWidth-2:0] mag;
    mag = x[DataTypeWidth-2:0];
    if (mag == '0)             fp_key = {1'b1, {(DataTypeWidth-1){1'b0}}};
    else if (x[DataTypeWidth-1]) fp_key = {1'b0, ~mag};
    else                       fp_key = {1'b1, mag};
  endfunction

  // Decode a threshold write into this level's slice of the heap.
  always_comb begin
    wc    = waddr_i[TotalAddrWidth-1:TreeDepth];
    wnode = waddr_i[TreeDepth-1:0];
    whit  = we_i && (32'(wnode) >= Base) && (32'(wnode) < Base + Nodes);
    widx  = IdxWidth'(32'(wnode) - Base);
  end

  // Threshold flops; a read in the write cycle still sees the old value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < int'(C); c++) begin
        for (int n = 0; n < int'(Nodes); n++) begin
          thr_q[c][n] <= '0;
        end
      end
    end else if (whit) begin
      thr_q[wc][widx] <= wdata_i;
    end
  end

  // Select this beat's node and decide left/right; ties go left.
  always_comb begin
    ridx = prefix_i[IdxWidth-1:0];
    feat = a_i[DataTypeWidth-1:0];
    thr  = thr_q[c_i][ridx];
    if (AccumulationOption == INT) bit_gt = $signed(feat) > $signed(thr);
    else                           bit_gt = fp_key(feat) > fp_key(thr);
  end

  // Stage register; idle stages carry zeros so outputs read 0 when invalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      c_q      <= '0;
      prefix_q <= '0;
      a_q      <= '0;
    end else begin
      valid_q  <= valid_i;
      c_q      <= valid_i ? c_i : '0;
      prefix_q <= valid_i ? {prefix_i[TreeDepth-2:0], bit_gt} : '0;
      a_q      <= valid_i ? (a_i >> DataTypeWidth) : '0;
    end
  end

  assign valid_o  = valid_q;
  assign c_o      = c_q;
  assign prefix_o = prefix_q;
  assign a_o      = a_q;

endmodule

// File: rtl/halut_encoder.sv
// Streams activation beats through a TreeDepth-stage decision-tree pipeline
// and emits (codebook, prototype) pairs for the decoder LUT.
// Handshake: valid_i marks one beat per cycle with no backpressure; a row is
// C consecutive beats, and encoder_o is valid for exactly the cycles whose
// c_addr_o/k_addr_o carry a result.
module halut_encoder
  import halut_pkg::*;
#(
  parameter int unsigned        K                  = halut_pkg::K,
  parameter int unsigned        C                  = halut_pkg::C,
  parameter int unsigned        DataTypeWidth      = halut_pkg::DataTypeWidth,
  parameter accumulation_enum_t AccumulationOption = halut_pkg::AccumulationOption,
  localparam int unsigned       TotalAddrWidth     = $clog2(C * K),
  localparam int unsigned       CAddrWidth         = $clog2(C),
  localparam int unsigned       TreeDepth          = $clog2(K)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [TotalAddrWidth-1:0]          waddr_i,
  input  logic [DataTypeWidth-1:0]           wdata_i,
  input  logic                               we_i,
  input  logic [TreeDepth*DataTypeWidth-1:0] a_i,
  input  logic                               valid_i,
  output logic [CAddrWidth-1:0]              c_addr_o,
  output logic [TreeDepth-1:0]               k_addr_o,
  output logic                               encoder_o,
  output logic                               abort_o
);

  logic [CAddrWidth-1:0] cnt_q, cnt_d;
  logic                  abort_q, abort_d;

  logic                               s_valid  [TreeDepth+1];
  logic [CAddrWidth-1:0]              s_c      [TreeDepth+1];
  logic [TreeDepth-1:0]               s_prefix [TreeDepth+1];
  logic [TreeDepth*DataTypeWidth-1:0] s_a      [TreeDepth+1];

  // Beat counter tags each beat with its codebook; a gap mid-row aborts it.
  always_comb begin
    cnt_d   = '0;
    abort_d = 1'b0;
    if (valid_i) begin
      cnt_d = (cnt_q == CAddrWidth'(C - 1)) ? '0 : cnt_q + 1'b1;
    end else begin
      abort_d = (cnt_q != '0);
    end
  end

  // Counter and abort pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign s_valid[0]  = valid_i;
  assign s_c[0]      = cnt_q;
  assign s_prefix[0] = '0;
  assign s_a[0]      = a_i;

  for (genvar l = 0; l < TreeDepth; l++) begin : g_level
    halut_encoder_level #(
      .Level             (l),
      .K                 (K),
      .C                 (C),
      .DataTypeWidth     (DataTypeWidth),
      .AccumulationOption(AccumulationOption)
    ) u_level (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .we_i    (we_i),
      .valid_i (s_valid[l]),
      .c_i     (s_c[l]),
      .prefix_i(s_prefix[l]),
      .a_i     (s_a[l]),
      .valid_o (s_valid[l+1]),
      .c_o     (s_c[l+1]),
      .prefix_o(s_prefix[l+1]),
      .a_o     (s_a[l+1])
    );
  end

  assign encoder_o = s_valid[TreeDepth];
  assign c_addr_o  = s_c[TreeDepth];
  assign k_addr_o  = s_prefix[TreeDepth];
  assign abort_o   = abort_q;

endmodule

// File: tb/tb_halut_encoder.sv
// Directed bench for halut_encoder: an INT and an FP16 instance share stimulus.
module tb_halut_encoder;
  import halut_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  waddr_i = '0;
  logic [15:0] wdata_i = '0;
  logic        we_i = 1'b0;
  logic [63:0] a_i = '0;
  logic        valid_i = 1'b0;

  logic [4:0] c_int, c_fp;
  logic [3:0] k_int, k_fp;
  logic       enc_int, enc_fp, ab_int, ab_fp;

  // Hand-computed prototype for the beat currently driven.
  logic [3:0] drv_k = '0;
  logic [3:0] drv_kf = '0;

  int n_checks = 0;
  int n_bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  halut_encoder #(.AccumulationOption(INT)) dut_int (
    .clk_i(clk), .rst_i(rst), .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i),
    .a_i(a_i), .valid_i(valid_i), .c_addr_o(c_int), .k_addr_o(k_int),
    .encoder_o(enc_int), .abort_o(ab_int)
  );

  halut_encoder #(.AccumulationOption(FP32)) dut_fp (
    .clk_i(clk), .rst_i(rst), .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i),
    .a_i(a_i), .valid_i(valid_i), .c_addr_o(c_fp), .k_addr_o(k_fp),
    .encoder_o(enc_fp), .abort_o(ab_fp)
  );

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- expected-output timeline ----------------
  logic       m_v  [4];
  logic [4:0] m_c  [4];
  logic [3:0] m_k  [4];
  logic [3:0] m_kf [4];
  logic [4:0] m_cnt;
  logic       m_abort;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_v[i] <= 1'b0; m_c[i] <= '0; m_k[i] <= '0; m_kf[i] <= '0;
      end
      m_cnt   <= '0;
      m_abort <= 1'b0;
    end else begin
      m_v[0]  <= valid_i;
      m_c[0]  <= valid_i ? m_cnt : 5'd0;
      m_k[0]  <= valid_i ? drv_k : 4'd0;
      m_kf[0] <= valid_i ? drv_kf : 4'd0;
      for (int i = 1; i < 4; i++) begin
        m_v[i] <= m_v[i-1]; m_c[i] <= m_c[i-1]; m_k[i] <= m_k[i-1]; m_kf[i] <= m_kf[i-1];
      end
      m_cnt   <= valid_i ? m_cnt + 5'd1 : 5'd0;
      m_abort <= !valid_i && (m_cnt != 5'd0);
    end
  end

  // Every cycle both instances must match the timeline {valid, c, k, abort}.
  always @(negedge clk) begin
    check_val("int_out", {21'd0, enc_int, c_int, k_int, ab_int}, {21'd0, m_v[3], m_c[3], m_k[3], m_abort});
    check_val("fp_out",  {21'd0, enc_fp,  c_fp,  k_fp,  ab_fp},  {21'd0, m_v[3], m_c[3], m_kf[3], m_abort});
  end

  // ---------------- drivers ----------------
  task automatic drive_cycle(input logic v, input logic [63:0] a, input logic [3:0] k,
                             input logic [3:0] kf, input logic we, input logic [8:0] wa,
                             input logic [15:0] wd);
    @(negedge clk);
    valid_i = v; a_i = a; drv_k = k; drv_kf = kf;
    we_i = we; waddr_i = wa; wdata_i = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, '0, 4'd0, 4'd0, 1'b0, '0, '0);
  endtask

  task automatic write_thr(input int c, input int node, input logic [15:0] val);
    drive_cycle(1'b0, '0, 4'd0, 4'd0, 1'b1, 9'(c * 16 + node), val);
  endtask

  // Beats for codebooks first_c.., all with the same features; codebook sp_c
  // gets its own expected prototype.
  task automatic drive_row(input int first_c, input int n, input logic [63:0] a,
                           input logic [3:0] k_def, input logic [3:0] kf_def,
                           input int sp_c, input logic [3:0] k_sp, input logic [3:0] kf_sp);
    for (int i = 0; i < n; i++) begin
      if (first_c + i == sp_c) drive_cycle(1'b1, a, k_sp, kf_sp, 1'b0, '0, '0);
      else                     drive_cycle(1'b1, a, k_def, kf_def, 1'b0, '0, '0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check_val("rst_enc",   {31'd0, enc_int}, 32'd0);
    check_val("rst_c",     {27'd0, c_int}, 32'd0);
    check_val("rst_k",     {28'd0, k_int}, 32'd0);
    check_val("rst_abort", {31'd0, ab_int}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All thresholds 0, features +5: every level goes right.
    drive_row(0, 32, {4{16'd5}}, 4'hF, 4'hF, -1, 4'h0, 4'h0);
    idle(6);

    // Negative features and exact ties both go left.
    drive_row(0, 16, {4{16'hFFFB}}, 4'h0, 4'h0, -1, 4'h0, 4'h0);
    drive_row(16, 16, {4{16'h0000}}, 4'h0, 4'h0, -1, 4'h0, 4'h0);
    idle(6);

    // Codebook 3 path root->2->6->14 gives 1110; others see zeros -> 1101.
    write_thr(3, 0, 16'd10);
    write_thr(3, 2, 16'd20);
    write_thr(3, 6, 16'hFFFF);
    write_thr(3, 14, 16'd7);
    write_thr(3, 15, 16'h7FFF);  // node K-1 is not a tree node
    drive_row(0, 32, {16'd3, 16'd0, 16'd21, 16'd11}, 4'hD, 4'hD, 3, 4'hE, 4'hE);
    idle(6);

    // Root 0x8000: -0 in FP16 (tie with +0), -32768 in INT.
    write_thr(0, 0, 16'h8000);
    drive_row(0, 32, 64'd0, 4'h0, 4'h0, 0, 4'h8, 4'h0);
    idle(6);

    // Root 1.0, feature 2.0 goes right in both encodings.
    write_thr(0, 0, 16'h3C00);
    drive_row(0, 32, {16'd0, 16'd0, 16'd0, 16'h4000}, 4'h8, 4'h8, -1, 4'h0, 4'h0);
    idle(6);

    // Broken row: 10 beats then a gap -> one abort pulse, next row restarts at 0.
    drive_row(0, 10, {4{16'h7FFF}}, 4'hF, 4'hF, -1, 4'h0, 4'h0);
    idle(8);
    drive_row(0, 32, {4{16'h7FFF}}, 4'hF, 4'hF, -1, 4'h0, 4'h0);
    idle(6);

    // Root write in the same cycle as the c=0 beat: that beat uses 1.0,
    // the following row sees 0x7000.
    drive_cycle(1'b1, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h3E00}, 4'hF, 4'hF, 1'b1, 9'd0, 16'h7000);
    drive_row(1, 31, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h3E00}, 4'hF, 4'hF, -1, 4'h0, 4'h0);
    drive_row(0, 32, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h3E00}, 4'hF, 4'hF, 0, 4'h7, 4'h7);
    idle(6);

    // Reset mid-row clears outputs without a clock edge.
    drive_row(0, 8, {4{16'h7FFF}}, 4'hF, 4'hF, -1, 4'h0, 4'h0);
    #1;
    check_val("pre_rst_enc", {31'd0, enc_int}, 32'd1);
    #1;
    rst = 1'b1;
    valid_i = 1'b0;
    drv_k = 4'd0;
    drv_kf = 4'd0;
    #1;
    check_val("async_rst_enc_int", {31'd0, enc_int}, 32'd0);
    check_val("async_rst_enc_fp",  {31'd0, enc_fp}, 32'd0);
    check_val("async_rst_c",       {27'd0, c_int}, 32'd0);
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    // Thresholds were cleared by reset; row restarts at c=0.
    drive_row(0, 32, {4{16'h7FFF}}, 4'hF, 4'hF, -1, 4'h0, 4'h0);
    idle(8);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
